// File: rtl/lsm_sequencer_pkg.sv
// Shared ARM definitions for the load/store-multiple sequencer: state encodings
// and word size.
package lsm_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } lsm_state_t;

  // Byte span covered by n words.
  function automatic logic [31:0] words_to_bytes(input logic [4:0] n);
    return 32'(n) * WORD_STEP;
  endfunction

endpackage

// File: rtl/prio_enc_16.sv
// Lowest-set-bit encoder: index of the lowest-numbered set bit plus a valid flag.
module prio_enc_16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    valid = |vec;
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a 16-bit register list and issues one
// memory beat per set bit, lowest register at the lowest address.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | waiting for START; latches list, P, U and base on acceptance
// ST_SETUP | one cycle: popcount, start address, writeback value
// ST_XFER  | beat valid; advances on MOC, holds otherwise
// ST_DONE  | one-cycle LSM_END pulse, then back to idle
module lsm_sequencer
  import lsm_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [15:0] REG_LIST,
  input  logic        P_BIT,
  input  logic        U_BIT,
  input  logic [31:0] BASE_ADDR,
  input  logic        MOC,
  output logic        BUSY,
  output logic        LSM_DETECT,
  output logic        MEM_REQ,
  output logic [3:0]  REG_NUM,
  output logic [31:0] ADDR,
  output logic [4:0]  COUNT,
  output logic [31:0] WB_ADDR,
  output logic        LSM_END
);

  lsm_state_t  state_q, state_d;
  logic [15:0] list_q;
  logic        p_q, u_q;
  logic [31:0] base_q;
  logic [31:0] addr_q;
  logic [4:0]  count_q;
  logic [31:0] wb_addr_q;
  logic        detect_q;

  logic [4:0]  pop_n;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_calc;
  logic [3:0]  enc_idx;
  logic        enc_valid;

  prio_enc_16 u_prio_enc (
    .vec   (list_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    pop_n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_n = pop_n + {4'd0, list_q[i]};
    end
  end

  // Decrementing modes start at the bottom of the block so beats always ascend.
  always_comb begin
    span = words_to_bytes(pop_n);
    unique case ({p_q, u_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + WORD_STEP;
      2'b00:   start_addr = base_q - span + WORD_STEP;
      default: start_addr = base_q - span;
    endcase
    wb_calc = u_q ? (base_q + span) : (base_q - span);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      list_q    <= '0;
      p_q       <= 1'b0;
      u_q       <= 1'b0;
      base_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wb_addr_q <= '0;
      detect_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (START) begin
            list_q <= REG_LIST;
            p_q    <= P_BIT;
            u_q    <= U_BIT;
            base_q <= BASE_ADDR;
          end
        end
        ST_SETUP: begin
          count_q   <= pop_n;
          detect_q  <= (pop_n != 5'd0);
          addr_q    <= start_addr;
          wb_addr_q <= wb_calc;
        end
        ST_XFER: begin
          if (MOC) begin
            list_q[enc_idx] <= 1'b0;
            addr_q          <= addr_q + WORD_STEP;
            count_q         <= count_q - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    BUSY    = 1'b0;
    MEM_REQ = 1'b0;
    LSM_END = 1'b0;
    REG_NUM = 4'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        BUSY    = 1'b1;
        state_d = (pop_n != 5'd0) ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        BUSY    = 1'b1;
        MEM_REQ = enc_valid;
        REG_NUM = enc_idx;
        if (MOC && (count_q == 5'd1)) state_d = ST_DONE;
      end
      default: begin
        BUSY    = 1'b1;
        LSM_END = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ADDR       = addr_q;
  assign COUNT      = count_q;
  assign WB_ADDR    = wb_addr_q;
  assign LSM_DETECT = detect_q;

endmodule

// File: doc/lsm_sequencer.md
LSM_SEQUENCER -- requirements
Module: lsm_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named CLK and RESET_N.
REQ-002 The block SHALL have these ports:
- CLK, input, 1: rising-edge clock.
- RESET_N, input, 1: synchronous active-low reset.
- START, input, 1: LSM_EN from the control unit; requests one load/store-multiple sequence.
- REG_LIST, input, 16: IR[15:0] register list.
- P_BIT, input, 1: IR[24] pre-index.
- U_BIT, input, 1: IR[23] up/down.
- BASE_ADDR, input, 32: Rn value (PA).
- MOC, input, 1: memory operation complete.
- BUSY, output, 1: sequence in progress.
- LSM_DETECT, output, 1: latched list is non-empty.
- MEM_REQ, output, 1: beat valid; drives MAR/MDR load.
- REG_NUM, output, 4: register for the current beat (muxA/muxC select).
- ADDR, output, 32: word address for the current beat.
- COUNT, output, 5: beats remaining.
- WB_ADDR, output, 32: base writeback value.
- LSM_END, output, 1: one-cycle completion pulse.

Function
REQ-003 The block SHALL implement states IDLE, SETUP, XFER and DONE.
REQ-004 IDLE: when START=1 at a rising edge, the block SHALL latch REG_LIST, P_BIT, U_BIT and BASE_ADDR and go to SETUP; BUSY=1 from the next cycle.
REQ-005 SETUP (exactly 1 cycle): the block SHALL compute n=popcount(list), COUNT=n and LSM_DETECT=(n!=0), plus the start address:
- IA (P=0,U=1): Rn.
- IB (P=1,U=1): Rn+4.
- DA (P=0,U=0): Rn-4n+4.
- DB (P=1,U=0): Rn-4n.
REQ-006 SETUP SHALL also set WB_ADDR = U ? Rn+4n : Rn-4n, then go to XFER if n!=0, else to DONE.
REQ-007 XFER: the block SHALL drive MEM_REQ=1, REG_NUM=lowest set bit of the remaining list, and ADDR=current address.
REQ-008 While MOC=0 in XFER, REG_NUM, ADDR and COUNT SHALL hold.
REQ-009 When MOC=1 is sampled in XFER, the block SHALL clear that list bit, advance ADDR by 4, decrement COUNT, and then:
- stay in XFER with the next beat valid the following cycle (back-to-back), or
- go to DONE if COUNT reaches 0.
REQ-010 Registers SHALL always be transferred lowest-numbered first at ascending addresses, for all four modes.
REQ-011 DONE: the block SHALL assert LSM_END=1 for exactly one cycle with MEM_REQ=0, then return to IDLE with BUSY=0.
REQ-012 START SHALL be ignored in every state other than IDLE, including DONE.
REQ-013 MOC SHALL be ignored outside XFER.
REQ-014 All address arithmetic SHALL be modulo 2^32, wrapping silently.
REQ-015 Latency SHALL be: START at edge k, SETUP during cycle k+1, first MEM_REQ in cycle k+2; an empty list gives LSM_END in cycle k+2.
REQ-016 WB_ADDR and LSM_DETECT SHALL remain valid from SETUP until the next START is accepted.

Reset
REQ-017 When RESET_N=0 is sampled at a rising edge, in any state including mid-XFER, the block SHALL go to IDLE.
REQ-018 On that reset, every output SHALL be 0, all latched fields SHALL be cleared, and no LSM_END SHALL be generated.
REQ-019 START SHALL not be accepted on an edge where RESET_N=0.

Structure
REQ-020 State encodings and the WORD_BYTES=4 constant SHALL live in the shared ARM definitions package/header.
REQ-021 The lowest-set-bit encoder SHALL be a separate sub-module, prio_enc_16 (16-bit in, 4-bit index plus valid out).
REQ-022 Popcount and all other logic SHALL remain inline.

Verification
REQ-023 IA, list 0x000F, base 0x100, MOC immediate: R0..R3 at 0x100/0x104/0x108/0x10C, WB_ADDR 0x110, one LSM_END pulse.
REQ-024 DB, list 0x8001, base 0x200: R0@0x1F8 then R15@0x1FC, WB_ADDR 0x1F8, COUNT goes 2,1,0.
REQ-025 List 0x0000: LSM_DETECT=0, MEM_REQ never asserted, LSM_END pulses in cycle k+2.
REQ-026 DA, list 0x0030, base 0x40, MOC delayed 3 cycles per beat: R4@0x3C and R5@0x40 each held 4 cycles, MEM_REQ continuously high, WB_ADDR 0x38.
REQ-027 IB, list 0x0003, base 0xFFFFFFFC: R0@0x00000000, R1@0x00000004 (wrap), WB_ADDR 0x00000004.
REQ-028 START pulsed mid-XFER is ignored; RESET_N=0 mid-XFER forces all outputs to 0 the next cycle with no LSM_END.
